// File: rtl/ascii_num_tokenizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascii_num_tokenizer: ASCII stream to decimal tokens with eol/blank/last.   |
// | Signed input is enabled by defining TOKENIZER_NEG_EN.  Revision 1.0        |
// +----------------------------------------------------------------------------+
module ascii_num_tokenizer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             input_valid,
  input  logic [7:0]       char_in,
  output logic             input_ready,
  input  logic             flush,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [WIDTH-1:0] tok_value,
  output logic             tok_num,
  output logic             tok_eol,
  output logic             tok_blank,
  output logic             tok_last
);

  localparam logic [7:0] c_lf    = 8'h0A;
  localparam logic [7:0] c_cr    = 8'h0D;
  localparam logic [7:0] c_zero  = 8'h30;
  localparam logic [7:0] c_nine  = 8'h39;
`ifdef TOKENIZER_NEG_EN
  localparam logic [7:0] c_minus = 8'h2D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_NUM = 2'd1, S_NEG = 2'd2, S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_NUM = 2'd1, S_DONE = 2'd3
  } state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic             r_line_start, w_line_start_nxt;
  logic             r_tok_valid, r_tok_num, r_tok_eol, r_tok_blank, r_tok_last;
  logic [WIDTH-1:0] r_tok_value;

  logic             w_accept_char, w_accept_flush, w_is_digit;
  logic [WIDTH-1:0] w_acc_base, w_acc_digit, w_num_value;
  logic             w_ld, w_ld_num, w_ld_eol, w_ld_blank, w_ld_last;
  logic [WIDTH-1:0] w_ld_value;

`ifdef TOKENIZER_NEG_EN
  logic r_neg, w_neg_nxt;
  assign w_num_value = r_neg ? (~r_acc + WIDTH'(1)) : r_acc;
`else
  assign w_num_value = r_acc;
`endif

  // Ready never looks at char_in/input_valid, so there is no input-to-output path.
  assign input_ready    = (r_state != S_DONE) & (~r_tok_valid | tok_ready);
  assign w_accept_char  = input_valid & input_ready;
  assign w_accept_flush = flush & ~input_valid & input_ready;
  assign w_is_digit     = (char_in >= c_zero) && (char_in <= c_nine);
  assign w_acc_base     = (r_state == S_NUM) ? r_acc : '0;
  assign w_acc_digit    = w_acc_base * WIDTH'(10) + (WIDTH'(char_in) - WIDTH'(c_zero));

  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_line_start_nxt = r_line_start;
`ifdef TOKENIZER_NEG_EN
    w_neg_nxt        = r_neg;
`endif
    w_ld       = 1'b0;
    w_ld_value = '0;
    w_ld_num   = 1'b0;
    w_ld_eol   = 1'b0;
    w_ld_blank = 1'b0;
    w_ld_last  = 1'b0;

    if (w_accept_flush) begin
      w_ld        = 1'b1;
      w_ld_num    = (r_state == S_NUM);
      w_ld_value  = (r_state == S_NUM) ? w_num_value : '0;
      w_ld_eol    = 1'b1;
      w_ld_last   = 1'b1;
      w_state_nxt = S_DONE;
    end else if (w_accept_char) begin
      if (w_is_digit) begin
        w_acc_nxt        = w_acc_digit;
        w_state_nxt      = S_NUM;
        w_line_start_nxt = 1'b0;
`ifdef TOKENIZER_NEG_EN
        w_neg_nxt = (r_state == S_NEG) | ((r_state == S_NUM) & r_neg);
`endif
      end else if (char_in == c_lf) begin
        w_ld             = 1'b1;
        w_ld_num         = (r_state == S_NUM);
        w_ld_value       = (r_state == S_NUM) ? w_num_value : '0;
        w_ld_eol         = 1'b1;
        w_ld_blank       = r_line_start & (r_state == S_IDLE);
        w_state_nxt      = S_IDLE;
        w_line_start_nxt = 1'b1;
      end else if (char_in != c_cr) begin
        // Any other character is a delimiter; it only emits when a number is open.
        w_line_start_nxt = 1'b0;
        w_state_nxt      = S_IDLE;
        if (r_state == S_NUM) begin
          w_ld       = 1'b1;
          w_ld_num   = 1'b1;
          w_ld_value = w_num_value;
        end
`ifdef TOKENIZER_NEG_EN
        if ((char_in == c_minus) && (r_state == S_IDLE)) begin
          w_state_nxt = S_NEG;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_line_start <= 1'b1;
`ifdef TOKENIZER_NEG_EN
      r_neg        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_line_start <= w_line_start_nxt;
`ifdef TOKENIZER_NEG_EN
      r_neg        <= w_neg_nxt;
`endif
    end
  end

  // Single token register: a load wins over a simultaneous handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tok_valid <= 1'b0;
      r_tok_value <= '0;
      r_tok_num   <= 1'b0;
      r_tok_eol   <= 1'b0;
      r_tok_blank <= 1'b0;
      r_tok_last  <= 1'b0;
    end else if (w_ld) begin
      r_tok_valid <= 1'b1;
      r_tok_value <= w_ld_value;
      r_tok_num   <= w_ld_num;
      r_tok_eol   <= w_ld_eol;
      r_tok_blank <= w_ld_blank;
      r_tok_last  <= w_ld_last;
    end else if (tok_ready) begin
      r_tok_valid <= 1'b0;
    end
  end

  assign tok_valid = r_tok_valid;
  assign tok_value = r_tok_value;
  assign tok_num   = r_tok_num;
  assign tok_eol   = r_tok_eol;
  assign tok_blank = r_tok_blank;
  assign tok_last  = r_tok_last;

endmodule
`default_nettype wire

// File: tb/tb_ascii_num_tokenizer.sv
`default_nettype none
// Bench for ascii_num_tokenizer: directed and random character strings checked
// against a string-level token model.
module tb_ascii_num_tokenizer;
  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] value;
    logic         num;
    logic         eol;
    logic         blank;
    logic         last;
  } tok_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         input_valid = 1'b0;
  logic [7:0]   char_in = 8'h00;
  logic         flush = 1'b0;
  logic         tok_ready = 1'b0;
  logic         input_ready, tok_valid, tok_num, tok_eol, tok_blank, tok_last;
  logic [W-1:0] tok_value;

  int   checks = 0;
  int   errors = 0;
  int   ready_pct = 100;
  tok_t got_q[$];
  tok_t exp_q[$];

  ascii_num_tokenizer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .input_valid(input_valid), .char_in(char_in),
    .input_ready(input_ready), .flush(flush), .tok_valid(tok_valid),
    .tok_ready(tok_ready), .tok_value(tok_value), .tok_num(tok_num),
    .tok_eol(tok_eol), .tok_blank(tok_blank), .tok_last(tok_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 tok_ready = (int'($urandom_range(99)) < ready_pct);
  end

  // A handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && tok_valid && tok_ready)
      got_q.push_back({tok_value, tok_num, tok_eol, tok_blank, tok_last});
  end

  function automatic tok_t mk(input logic [W-1:0] v, input logic n, input logic e,
                              input logic b, input logic l);
    tok_t t;
    t.value = v; t.num = n; t.eol = e; t.blank = b; t.last = l;
    return t;
  endfunction

  // Reference: walk the string, tracking an open number, a pending '-' and
  // whether anything but CR has appeared on the current line.
  function automatic void model(input string s, input bit fl);
    logic [W-1:0] acc = '0;
    logic [W-1:0] v;
    logic [7:0]   c;
    bit have = 0, minus = 0, neg = 0, ls = 1;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      v = neg ? (W'(0) - acc) : acc;
      if (c >= "0" && c <= "9") begin
        if (!have) begin acc = '0; neg = minus; end
        acc = acc * 10 + W'(c - "0");
        have = 1; minus = 0; ls = 0;
      end else if (c == 8'h0A) begin
        exp_q.push_back(mk(have ? v : '0, have, 1, ls && !have && !minus, 0));
        have = 0; minus = 0; neg = 0; ls = 1;
      end else if (c != 8'h0D) begin
        if (have) exp_q.push_back(mk(v, 1, 0, 0, 0));
`ifdef TOKENIZER_NEG_EN
        minus = (c == "-") && !have && !minus;
`else
        minus = 0;
`endif
        have = 0; ls = 0;
      end
    end
    v = neg ? (W'(0) - acc) : acc;
    if (fl) exp_q.push_back(mk(have ? v : '0, have, 1, 0, 1));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; input_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    got_q.delete(); exp_q.delete();
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input string s, input int gap);
    int i = 0;
    int guard = 0;
    while (i < s.len()) begin
      @(posedge clk); #1;
      if (int'($urandom_range(99)) < gap) input_valid = 1'b0;
      else begin input_valid = 1'b1; char_in = s[i]; end
      @(negedge clk);
      if (input_valid && input_ready) i++;
      guard++;
      if (guard > 3000) begin
        checks++; errors++;
        $display("FAIL send_timeout: accepted %0d chars, required %0d", i, s.len());
        break;
      end
    end
    @(posedge clk); #1 input_valid = 1'b0;
  endtask

  task automatic send_flush();
    int guard = 0;
    @(posedge clk); #1 flush = 1'b1; input_valid = 1'b0;
    @(negedge clk);
    while (!input_ready && guard < 500) begin @(negedge clk); guard++; end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL flush_timeout: input_ready=%0b, required 1", input_ready);
    end
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (got_q.size() < exp_q.size() && guard < 500) begin @(posedge clk); guard++; end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    ready_pct = 0;
    send("7\n", 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tok_valid, tok_num, tok_eol, tok_blank, tok_last} !== 5'b0 || tok_value !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b value=%0h flags=%0b%0b%0b%0b, required all 0",
               tok_valid, tok_value, tok_num, tok_eol, tok_blank, tok_last);
    end
    checks++;
    if (input_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: input_ready=%0b, required 1", input_ready);
    end
    ready_pct = 100;
    do_reset();
  endtask

  task automatic test_patterns();
    string pats[$];
    pats = '{"12,345\n", "5\n\n7\n", "18446744073709551617\n", "\nab 7x\015\n\015\n0,,9 \n",
             "3-4\n"};
`ifdef TOKENIZER_NEG_EN
    pats.push_back("-5\n");
    pats.push_back("-x\n");
    pats.push_back("--7,-0\n");
`endif
    for (int p = 0; p < pats.size(); p++) begin
      do_reset();
      ready_pct = 100;
      model(pats[p], 0);
      send(pats[p], 0);
      wait_drain();
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL pattern%0d_count: got %0d tokens, required %0d", p, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL pattern%0d_tok%0d: got v=%0h n%0b e%0b b%0b l%0b, required v=%0h n%0b e%0b b%0b l%0b",
                   p, k, got_q[k].value, got_q[k].num, got_q[k].eol, got_q[k].blank, got_q[k].last,
                   exp_q[k].value, exp_q[k].num, exp_q[k].eol, exp_q[k].blank, exp_q[k].last);
        end
      end
    end
  endtask

  task automatic test_stall();
    int guard = 0;
    do_reset();
    model("8 9\n", 0);
    ready_pct = 0;
    fork
      send("8 9\n", 0);
      begin
        @(negedge clk);
        while (!tok_valid && guard < 50) begin @(negedge clk); guard++; end
        for (int c = 0; c < 5; c++) begin
          checks++;
          if (input_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready cycle%0d: input_ready=%0b, required 0", c, input_ready);
          end
          checks++;
          if (tok_valid !== 1'b1 || tok_value !== W'(8) || tok_num !== 1'b1 || tok_eol !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cycle%0d: valid=%0b value=%0h num=%0b eol=%0b, required 1 8 1 0",
                     c, tok_valid, tok_value, tok_num, tok_eol);
          end
          @(negedge clk);
        end
        ready_pct = 100;
      end
    join
    wait_drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d tokens, required %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL stall_tok%0d: got v=%0h, required v=%0h", k, got_q[k].value, exp_q[k].value);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    ready_pct = 100;
    send("42", 0);
    send_flush();
    wait_drain();
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== mk(W'(42), 1, 1, 0, 1)) begin
      errors++;
      $display("FAIL flush_token: got %0d tokens (first %0h), required one {42,num,eol,last}",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      input_valid = c[0]; char_in = 8'h0A; flush = ~c[0];
      @(negedge clk);
      checks++;
      if (input_ready !== 1'b0) begin
        errors++;
        $display("FAIL done_ready cycle%0d: input_ready=%0b, required 0", c, input_ready);
      end
    end
    @(posedge clk); #1 input_valid = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL done_silent: got %0d tokens, required 1", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_pct = 100;
    send("ab12", 0);
    do_reset();
    model("\n3\n", 0);
    send("\n3\n", 0);
    wait_drain();
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== mk('0, 0, 1, 1, 0) || got_q[1] !== mk(W'(3), 1, 1, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid: got %0d tokens, required blank then 3", got_q.size());
    end
  endtask

  task automatic test_random();
    string alpha = "0123456789012345,,\n\n\015 -x";
    string s;
    bit    fl;
    int    len;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      s = "";
      len = int'($urandom_range(60, 10));
      for (int j = 0; j < len; j++) begin
        int k = int'($urandom_range(alpha.len() - 1));
        s = {s, alpha.substr(k, k)};
      end
      fl = 1'($urandom_range(1));
      ready_pct = int'($urandom_range(100, 30));
      model(s, fl);
      send(s, int'($urandom_range(40)));
      if (fl) send_flush();
      wait_drain();
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL random%0d_count: got %0d tokens, required %0d", it, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL random%0d_tok%0d: got v=%0h n%0b e%0b b%0b l%0b, required v=%0h n%0b e%0b b%0b l%0b",
                   it, k, got_q[k].value, got_q[k].num, got_q[k].eol, got_q[k].blank, got_q[k].last,
                   exp_q[k].value, exp_q[k].num, exp_q[k].eol, exp_q[k].blank, exp_q[k].last);
        end
      end
    end
    ready_pct = 100;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascii_num_tokenizer.md
# ascii_num_tokenizer

Converts the ASCII character stream delivered by the file-reader harness into decimal integer tokens with line-structure flags, so puzzle solver cores consume numbers instead of raw characters. It sits directly downstream of the character source, which drives `input_valid`/`char_in` and honours `input_ready`. It sits upstream of a solver core, which consumes tokens over a valid/ready handshake. Arithmetic is unsigned wrap-around at `WIDTH` bits; signed input is optional via a macro.

## Interface
- `WIDTH`, 64, token value width; accumulation is modulo 2^WIDTH.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `input_valid`  in  1  `char_in` holds a character.
- `char_in`  in  8  ASCII character.
- `input_ready`  out  1  character (or flush) accepted this cycle when high.
- `flush`  in  1  end-of-stream request, held by upstream until accepted.
- `tok_valid`  out  1  token register full.
- `tok_ready`  in  1  consumer takes token when `tok_valid & tok_ready`.
- `tok_value`  out  WIDTH  parsed number; 0 when `tok_num`=0.
- `tok_num`  out  1  token carries a number.
- `tok_eol`  out  1  token terminated by `'\n'` or by flush.
- `tok_blank`  out  1  `'\n'` seen at line start (empty line).
- `tok_last`  out  1  final token, produced by flush.

## Operation
- States:
  - IDLE: no digits pending.
  - NUM: accumulating.
  - NEG: `'-'` seen; exists only with the macro.
  - DONE: flushed.
- Register `at_line_start` is set by reset and by every accepted `'\n'`. It is cleared by any other accepted character except `'\r'`.
- Digit `'0'..'9'` in IDLE, NUM or NEG:
  - `acc <= acc*10 + d`, truncated to WIDTH; the state goes to NUM.
  - In IDLE, `acc` restarts from 0.
  - No token is produced.
- `'\n'`:
  - Always emits one token with `tok_eol`=1.
  - `tok_num`=1 with `tok_value`=acc if the state was NUM; otherwise `tok_num`=0 and `tok_value`=0.
  - `tok_blank`=`at_line_start & state==IDLE`.
  - Next state is IDLE.
- `'\r'` is ignored entirely: no state change and no `at_line_start` change.
- Any other character:
  - In NUM, emits a number token with `tok_eol`=0; next state is IDLE.
  - In IDLE, it is dropped.
- Flush:
  - Accepted only when `input_ready=1` and `input_valid=0`. If `input_valid=1` in the same cycle, the character is processed and flush waits.
  - Emits one token with `tok_last`=1, `tok_eol`=1, `tok_blank`=0, and `tok_num`=(state==NUM).
  - Next state is DONE.
- DONE: `input_ready`=0, all input is ignored, and the state is left only by reset.
- Output handshake:
  - Single token register.
  - `input_ready = (state!=DONE) & (~tok_valid | tok_ready)`.
  - The token register loads on the edge that accepts a token-producing character or flush. `tok_valid` clears on a handshake with no simultaneous load.
  - Token fields are stable while `tok_valid & ~tok_ready`.
- Reset mid-stream:
  - The pending number is discarded, the state returns to IDLE, and `at_line_start`=1.
  - All outputs reset to 0 except `input_ready`, which is 1 immediately after reset.

## Timing
- A token is visible the cycle after the terminating character or flush is accepted: latency 1.
- Throughput is one character per cycle with `tok_ready` held high. Back-to-back tokens are supported when a handshake and a new load occur in the same cycle.
- Backpressure: `input_ready` is low whenever `tok_valid & ~tok_ready`. Digits are also stalled in that case, which keeps the rule uniform.
- No combinational path from `char_in` or `input_valid` to any output. `input_ready` depends combinationally only on `tok_ready` and registers.

## Configuration
- `TOKENIZER_NEG_EN` defined:
  - `'-'` in IDLE enters NEG.
  - A digit moves NEG to NUM with a negate flag set; the emitted `tok_value` = `(~acc)+1` (two's complement, WIDTH bits).
  - NEG followed by `'\n'` emits a `tok_num`=0 eol token. NEG followed by any other non-digit returns to IDLE with no token.
  - `'-'` while in NUM terminates the number as a delimiter.
- `TOKENIZER_NEG_EN` undefined: `'-'` is an ordinary delimiter and the NEG state and negate flag are not built.

## Test plan
- `"12,345\n"`, `tok_ready`=1 → tokens `{12,num=1,eol=0}` then `{345,num=1,eol=1}`; nothing else.
- `"5\n\n7\n"` → `{5,eol}`, then `{0,num=0,eol=1,blank=1}`, then `{7,eol}`.
- `"8 9\n"` with `tok_ready` low for 5 cycles after the first token → `input_ready` is low during the stall; tokens 8 and 9 are delivered intact; no character is lost.
- `"42"` then flush held with `input_valid`=0 → `{42,num=1,eol=1,last=1}`; `input_ready` stays 0 afterwards.
- `"18446744073709551617\n"` with WIDTH=64 → `tok_value`=1 (wrap-around). Reset asserted mid-number, then `"3\n"` → only token 3.
- With `TOKENIZER_NEG_EN` defined: `"-5\n"` → `tok_value`=0xFFFF_FFFF_FFFF_FFFB. `"-x\n"` → a single `{num=0,eol=1,blank=0}` token.
